// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_e;

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  // Width needed to count 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Free-running settle counter; expire flags the sampling cycle of each vector.
module settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int TW = clog2(SETTLE);

  logic [TW-1:0] cnt;

  assign expire = (cnt == TW'(SETTLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else            cnt <= cnt + TW'(1);
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational block, waits SETTLE cycles per
// vector and scores the response against a packed expected truth table.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 5,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'h96
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop_on_fail,
  output logic [N_IN-1:0]         stim,
  input  logic [N_OUT-1:0]        resp,
  output logic                    busy,
  output logic                    done,
  output logic [cnt_w(N_IN)-1:0]  pass_cnt,
  output logic [cnt_w(N_IN)-1:0]  fail_cnt,
  output logic [N_IN-1:0]         first_fail_vec,
  output logic                    first_fail_valid
);

  localparam int CW = cnt_w(N_IN);

  state_e           state_q, state_d;
  logic             sof_q;
  logic             expire, clear;
  logic             last, match, end_sweep;
  logic [N_OUT-1:0] exp_resp;

  // Timer idles at zero outside SETTLE so the first vector gets a full window.
  assign clear = (state_q != S_SETTLE) || expire;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .expire (expire)
  );

  assign exp_resp  = EXPECTED[int'(stim)*N_OUT +: N_OUT];
  assign match     = (resp == exp_resp);
  assign last      = &stim;
  assign end_sweep = last || (!match && sof_q);

  assign busy = (state_q == S_SETTLE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (expire && end_sweep) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim             <= '0;
      sof_q            <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            stim             <= '0;
            sof_q            <= stop_on_fail;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (expire) begin
            if (match) begin
              pass_cnt <= pass_cnt + CW'(1);
            end else begin
              fail_cnt <= fail_cnt + CW'(1);
              if (!first_fail_valid) begin
                first_fail_vec   <= stim;
                first_fail_valid <= 1'b1;
              end
            end
            // stim freezes on the final or failing vector for post-run inspection
            if (!end_sweep) stim <= stim + N_IN'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Table-driven and randomized checks of truth_table_sweeper against a sweep model.
module tb_truth_table_sweeper;

  localparam int N_IN   = 3;
  localparam int N_OUT  = 1;
  localparam int SETTLE = 5;
  localparam logic [7:0] EXP_TT = 8'h96;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic [2:0] stim;
  logic       resp;
  logic       busy, done;
  logic [3:0] pass_cnt, fail_cnt;
  logic [2:0] first_fail_vec;
  logic       first_fail_valid;

  int         mode = 0;          // 0 parity, 1 stuck-at-0, 2 random table
  logic [7:0] rand_tbl = '0;

  int n_cmp = 0;
  int n_bad = 0;

  int r_de, r_pass, r_fail, r_ffv, r_ffvec, r_stim;

  always #5 clk = ~clk;

  always_comb begin
    resp = 1'b0;
    case (mode)
      0:       resp = ^stim;
      1:       resp = 1'b0;
      default: resp = rand_tbl[stim];
    endcase
  end

  truth_table_sweeper #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE), .EXPECTED(EXP_TT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stop_on_fail     (stop_on_fail),
    .stim             (stim),
    .resp             (resp),
    .busy             (busy),
    .done             (done),
    .pass_cnt         (pass_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".stim"}, 32'(stim), 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".pass"}, 32'(pass_cnt), 0);
    chk({nm, ".fail"}, 32'(fail_cnt), 0);
    chk({nm, ".ffvec"}, 32'(first_fail_vec), 0);
    chk({nm, ".ffv"}, 32'(first_fail_valid), 0);
  endtask

  // Edge 0 is the edge that samples start; results are captured while done is high.
  task automatic run_sweep(input int m, input bit sof, input bit glitch);
    int e, bad_busy, bad_stim;
    e = 0; bad_busy = 0; bad_stim = 0; r_de = -1;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    stop_on_fail = sof;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = ~sof;
    while (1) begin
      if (done === 1'b1) begin
        r_de = e;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (int'(stim) != e / SETTLE) bad_stim++;
      if (e >= 200) break;
      start = glitch && (e + 1 == 3 || e + 1 == 40);
      @(posedge clk); #1;
      e++;
    end
    chk("done_seen", 32'(r_de >= 0), 1);
    chk("busy_during_sweep_errs", 32'(bad_busy), 0);
    chk("stim_hold_errs", 32'(bad_stim), 0);
    chk("busy_with_done", 32'(busy), 0);
    r_pass = int'(pass_cnt); r_fail = int'(fail_cnt);
    r_ffv = int'(first_fail_valid); r_ffvec = int'(first_fail_vec);
    r_stim = int'(stim);
    start = glitch;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = 1'b0;
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
    chk("stim_held", 32'(stim), 32'(r_stim));
  endtask

  task automatic model(input logic [7:0] tbl, input bit sof,
                       output int p, output int f, output int ffv,
                       output int ffvec, output int endv);
    p = 0; f = 0; ffv = 0; ffvec = 0; endv = 7;
    for (int v = 0; v < 8; v++) begin
      if (tbl[v] == EXP_TT[v]) p++;
      else begin
        f++;
        if (ffv == 0) begin ffv = 1; ffvec = v; end
        if (sof) begin endv = v; break; end
      end
    end
  endtask

  typedef struct {
    int mode; bit sof; bit glitch;
    int de; int p; int f; int ffv; int ffvec; int st;
  } row_t;

  row_t rows[6];

  task automatic chk_results(input string nm, input int de, input int p, input int f,
                             input int ffv, input int ffvec, input int st);
    chk({nm, ".done_edge"}, 32'(r_de), 32'(de));
    chk({nm, ".pass"}, 32'(r_pass), 32'(p));
    chk({nm, ".fail"}, 32'(r_fail), 32'(f));
    chk({nm, ".ffv"}, 32'(r_ffv), 32'(ffv));
    if (ffv != 0) chk({nm, ".ffvec"}, 32'(r_ffvec), 32'(ffvec));
    chk({nm, ".stim"}, 32'(r_stim), 32'(st));
  endtask

  initial begin
    int p, f, ffv, ffvec, endv;
    bit sof;
    int done_in_rst;

    // mode, sof, glitch, done_edge, pass, fail, ffv, ffvec, final stim
    rows[0] = '{0, 1'b0, 1'b0, 40, 8, 0, 0, 0, 7};
    rows[1] = '{1, 1'b0, 1'b0, 40, 4, 4, 1, 1, 7};
    rows[2] = '{1, 1'b1, 1'b0, 10, 1, 1, 1, 1, 1};
    rows[3] = '{0, 1'b0, 1'b1, 40, 8, 0, 0, 0, 7};
    rows[4] = '{0, 1'b1, 1'b0, 40, 8, 0, 0, 0, 7};
    rows[5] = '{1, 1'b1, 1'b1, 10, 1, 1, 1, 1, 1};

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 chk_all_zero("idle_after_reset");

    for (int i = 0; i < 6; i++) begin
      run_sweep(rows[i].mode, rows[i].sof, rows[i].glitch);
      chk_results($sformatf("row%0d", i), rows[i].de, rows[i].p, rows[i].f,
                  rows[i].ffv, rows[i].ffvec, rows[i].st);
    end

    // Reset mid-sweep at edge 17: outputs drop at once and no done follows.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_all_zero("mid_sweep_reset");
    done_in_rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_in_rst++;
    end
    chk("no_done_in_reset", 32'(done_in_rst), 0);
    @(negedge clk) rst = 1'b0;
    run_sweep(0, 1'b0, 1'b0);
    chk_results("after_reset", 40, 8, 0, 0, 0, 7);

    for (int i = 0; i < 24; i++) begin
      rand_tbl = 8'($urandom);
      sof = 1'($urandom_range(0, 1));
      model(rand_tbl, sof, p, f, ffv, ffvec, endv);
      run_sweep(2, sof, 1'b0);
      chk_results($sformatf("rand%0d", i), SETTLE * (endv + 1), p, f, ffv, ffvec, endv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
